// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three write requesters onto one register-file
// write port through a single registered output stage.
module regfile_write_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        req2_i,
    input  logic [4:0]  reg0_i,
    input  logic [4:0]  reg1_i,
    input  logic [4:0]  reg2_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        hold_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        gnt2_o,
    output logic        reg_write_o,
    output logic [4:0]  write_register_o,
    output logic [31:0] write_data_o,
    output logic [31:0] pending_mask_o,
    output logic [15:0] write_count_o
);

    typedef enum logic {IDLE, WRITE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;

    logic [2:0]  req_v;
    logic [2:0]  gnt;
    logic [1:0]  gidx;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;
    logic        rw;
    logic [31:0] pend;

    // Reset forces grants low even with requests present.
    always_comb begin
        req_v = {req2_i, req1_i, req0_i} & {3{~hold_i & rst_ni}};
        gnt   = 3'b000;
        case (ptr_q)
            2'd1: begin
                if (req_v[1])      gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
            end
            2'd2: begin
                if (req_v[2])      gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
            end
            default: begin
                if (req_v[0])      gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
            end
        endcase
        xfer = |gnt;
        gidx = 2'd0;
        unique case (1'b1)
            gnt[1]:  gidx = 2'd1;
            gnt[2]:  gidx = 2'd2;
            default: gidx = 2'd0;
        endcase
    end

    always_comb begin
        sel_reg  = reg0_i;
        sel_data = data0_i;
        case (gidx)
            2'd1: begin
                sel_reg  = reg1_i;
                sel_data = data1_i;
            end
            2'd2: begin
                sel_reg  = reg2_i;
                sel_data = data2_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = xfer ? WRITE : IDLE;
        ptr_d   = ptr_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            ptr_d   = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            wreg_d  = sel_reg;
            wdata_d = sel_data;
            cnt_d   = cnt_q + 16'd1;
        end
    end

    // Register 0 writes are granted and counted but never enabled.
    always_comb begin
        rw               = (state_q == WRITE) && (wreg_q != 5'd0);
        reg_write_o      = rw;
        write_register_o = wreg_q;
        write_data_o     = wdata_q;
        write_count_o    = cnt_q;
        gnt0_o           = gnt[0];
        gnt1_o           = gnt[1];
        gnt2_o           = gnt[2];
    end

    always_comb begin
        pend = 32'd0;
        for (int r = 1; r < 32; r++) begin
            pend[r] = (req0_i && reg0_i == 5'(r))
                   || (req1_i && reg1_i == 5'(r))
                   || (req2_i && reg2_i == 5'(r))
                   || (rw && wreg_q == 5'(r));
        end
        pending_mask_o = rst_ni ? pend : 32'd0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against
// a round-robin transaction model.
module tb_regfile_write_arbiter;

    logic        clk, rst_n, hold;
    logic [2:0]  req;
    logic [4:0]  rg [3];
    logic [31:0] dt [3];
    logic        gnt0, gnt1, gnt2, rw;
    logic [4:0]  wreg;
    logic [31:0] wdata, pm;
    logic [15:0] wc;

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    bit          m_valid;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [15:0] m_cnt;
    int          last_g;

    regfile_write_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req[0]), .req1_i(req[1]), .req2_i(req[2]),
        .reg0_i(rg[0]), .reg1_i(rg[1]), .reg2_i(rg[2]),
        .data0_i(dt[0]), .data1_i(dt[1]), .data2_i(dt[2]),
        .hold_i(hold),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .gnt2_o(gnt2),
        .reg_write_o(rw), .write_register_o(wreg),
        .write_data_o(wdata), .pending_mask_o(pm),
        .write_count_o(wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_ptr   = 0;
        m_valid = 0;
        m_reg   = 0;
        m_data  = 0;
        m_cnt   = 0;
    endtask

    function automatic int exp_grant();
        int k;
        if (!rst_n || hold) return -1;
        for (int i = 0; i < 3; i++) begin
            k = (m_ptr + i) % 3;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_pm();
        logic [31:0] v = 0;
        if (!rst_n) return 0;
        for (int r = 1; r < 32; r++) begin
            for (int n = 0; n < 3; n++)
                if (req[n] && rg[n] == r) v[r] = 1'b1;
            if (m_valid && m_reg == r) v[r] = 1'b1;
        end
        return v;
    endfunction

    task automatic cycle();
        int g;
        logic [31:0] eg;
        #1;
        g  = exp_grant();
        eg = (g < 0) ? 32'd0 : (32'd1 << g);
        chk("gnt", {29'd0, gnt2, gnt1, gnt0}, eg);
        chk("pmask", pm, exp_pm());
        chk("regwrite", rw, (m_valid && m_reg != 0) ? 1 : 0);
        chk("wreg", wreg, m_reg);
        chk("wdata", wdata, m_data);
        chk("wcount", wc, m_cnt);
        last_g = g;
        @(posedge clk);
        if (!rst_n) mreset();
        else if (g >= 0) begin
            m_valid = 1;
            m_reg   = rg[g];
            m_data  = dt[g];
            m_cnt   = m_cnt + 16'd1;
            m_ptr   = (g + 1) % 3;
        end else m_valid = 0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mreset();
        cycle();
        chk("rst_cnt", wc, 0);
        chk("rst_rw", rw, 0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        req   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            rg[k] = 0;
            dt[k] = 0;
        end
        mreset();
        #2;
        do_reset();

        req = 3'b111;
        rg  = '{5'd1, 5'd2, 5'd3};
        dt  = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r36_gnt", {29'd0, gnt2, gnt1, gnt0},
                32'd1 << (i % 3));
            cycle();
            chk("r36_wreg", wreg, 32'(i % 3 + 1));
            chk("r36_rw", rw, 1);
        end

        req = 3'b111;
        do_reset();
        req = 3'b010;
        rg[1] = 0;
        dt[1] = 32'h1234;
        #1;
        chk("r37_gnt1", gnt1, 1);
        cycle();
        req = 0;
        chk("r37_rw", rw, 0);
        chk("r37_cnt", wc, 1);

        do_reset();
        req = 3'b101;
        rg[0] = 16; dt[0] = 5;
        rg[2] = 16; dt[2] = 9;
        cycle();
        req[0] = 0;
        chk("r38_d5", wdata, 5);
        chk("r38_pm1", pm[16], 1);
        cycle();
        req[2] = 0;
        chk("r38_d9", wdata, 9);
        chk("r38_pm2", pm[16], 1);
        cycle();
        chk("r38_pm3", pm[16], 0);

        req = 3'b111;
        rg  = '{5'd4, 5'd5, 5'd6};
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("r39_cnt", wc, 3);
        chk("r39_rw", rw, 0);
        hold = 1'b0;
        #1;
        chk("r39_resume", {29'd0, gnt2, gnt1, gnt0}, 32'd2);
        cycle();

        req = 3'b001;
        rg[0] = 5;
        dt[0] = 32'hDEAD;
        cycle();
        req = 0;
        chk("r40_pre", rw, 1);
        rst_n = 1'b0;
        mreset();
        #1;
        chk("r40_rw", rw, 0);
        chk("r40_wd", wdata, 0);
        chk("r40_wc", wc, 0);
        cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if (last_g >= 0) req[last_g] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!req[k] && ($urandom % 2 == 0)) begin
                    req[k] = 1'b1;
                    rg[k]  = ($urandom % 4 == 0) ? 5'd16
                           : ($urandom % 8 == 0) ? 5'd0
                           : 5'($urandom);
                    dt[k]  = $urandom;
                end else if (req[k] && ($urandom % 16 == 0)) begin
                    req[k] = 1'b0;
                end
            end
            hold = ($urandom % 6 == 0);
            if ($urandom % 500 == 0) begin
                rst_n = 1'b0;
                mreset();
                cycle();
                rst_n = 1'b1;
            end else cycle();
        end

        hold = 1'b0;
        req  = 0;
        do_reset();
        req   = 3'b001;
        rg[0] = 7;
        for (int i = 0; i < 65535; i++) begin
            dt[0] = i;
            cycle();
        end
        chk("wrap_ffff", wc, 16'hFFFF);
        cycle();
        chk("wrap_0", wc, 0);
        req = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
